// File: rtl/vertex_xform_pipe.sv
// vertex_xform_pipe
//   Streams object-space vertices (x, y, z, implied w = 1.0) in signed
//   fixed-point Q(M).(N) through a double-buffered 4x4 fixed-point matrix.
//   Emits rounded M-bit signed integer (x, y, z, w).
//   Three pipeline stages: products, row sums, round/range-reduce.
//
// Build option:
//   VERTEX_XFORM_SAT_EN  defined   -> out-of-range results clamp, sat_flag sticky
//                        undefined -> results wrap to M bits, sat_flag = 0
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   mat_we, mat_addr, mat_wdata      write one shadow-matrix entry (row*4+col)
//   mat_commit                       copy shadow bank to active bank
//   in_valid/in_ready, in_x/y/z      input vertex handshake and coordinates
//   out_valid/out_ready, out_x/y/z/w output vertex handshake and results
//   vtx_count                        completed output handshakes (wraps)
//   sat_flag                         sticky out-of-range indicator
module vertex_xform_pipe #(
    parameter int M = 11,
    parameter int N = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mat_we,
    input  logic [3:0]       mat_addr,
    input  logic [M+N-1:0]   mat_wdata,
    input  logic             mat_commit,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M+N-1:0]   in_x,
    input  logic [M+N-1:0]   in_y,
    input  logic [M+N-1:0]   in_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out_x,
    output logic [M-1:0]     out_y,
    output logic [M-1:0]     out_z,
    output logic [M-1:0]     out_w,
    output logic [31:0]      vtx_count,
    output logic             sat_flag
);

    localparam int W  = M + N;
    localparam int PW = 2 * W;
    localparam int SW = PW + 2;

    localparam logic signed [W-1:0] ONE_Q = W'(1 << N);
    localparam logic signed [SW:0]  HALF  = (SW+1)'(64'd1 << (2*N-1));
`ifdef VERTEX_XFORM_SAT_EN
    localparam logic signed [SW:0]  MAX_V = (SW+1)'((64'sd1 <<< (M-1)) - 64'sd1);
    localparam logic signed [SW:0]  MIN_V = -MAX_V - (SW+1)'(1);
`endif

    logic signed [W-1:0]  shadow_q [16];
    logic signed [W-1:0]  shadow_d [16];
    logic signed [W-1:0]  active_q [16];
    logic signed [W-1:0]  active_d [16];
    logic signed [PW-1:0] prod_q [16];
    logic signed [PW-1:0] prod_d [16];
    logic signed [SW-1:0] sum_q [4];
    logic signed [SW-1:0] sum_d [4];
    logic [M-1:0]         res_q [4];
    logic [M-1:0]         res_d [4];
    logic                 s1_valid_q, s1_valid_d;
    logic                 s2_valid_q, s2_valid_d;
    logic                 s3_valid_q, s3_valid_d;
    logic [31:0]          cnt_q, cnt_d;
    logic                 ce;
    logic signed [W-1:0]  vec [4];
    logic signed [SW:0]   rnd [4];
    logic signed [SW:0]   rsh [4];
`ifdef VERTEX_XFORM_SAT_EN
    logic                 sat_q, sat_d;
`endif

    assign ce       = !s3_valid_q || out_ready;
    assign in_ready = ce;

    // Commit reads shadow_q, so a write in the same cycle reaches shadow only.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = mat_commit ? shadow_q[i] : active_q[i];
        end
        if (mat_we) shadow_d[mat_addr] = mat_wdata;
    end

    // Products use active_q, i.e. the matrix in force on the acceptance cycle.
    always_comb begin
        vec[0] = in_x;
        vec[1] = in_y;
        vec[2] = in_z;
        vec[3] = ONE_Q;
        for (int i = 0; i < 16; i++) begin
            prod_d[i] = prod_q[i];
            if (ce && in_valid) prod_d[i] = PW'(active_q[i]) * PW'(vec[i % 4]);
        end
    end

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            sum_d[r] = sum_q[r];
            if (ce && s1_valid_q) begin
                sum_d[r] = SW'(prod_q[r*4])   + SW'(prod_q[r*4+1]) +
                           SW'(prod_q[r*4+2]) + SW'(prod_q[r*4+3]);
            end
        end
    end

    // Round half toward +inf, then range-reduce to M bits.
    always_comb begin
`ifdef VERTEX_XFORM_SAT_EN
        sat_d = sat_q;
`endif
        for (int r = 0; r < 4; r++) begin
            rnd[r]   = (SW+1)'(sum_q[r]) + HALF;
            rsh[r]   = rnd[r] >>> (2*N);
            res_d[r] = res_q[r];
            if (ce && s2_valid_q) begin
`ifdef VERTEX_XFORM_SAT_EN
                if (rsh[r] > MAX_V) begin
                    res_d[r] = M'(MAX_V);
                    sat_d    = 1'b1;
                end else if (rsh[r] < MIN_V) begin
                    res_d[r] = M'(MIN_V);
                    sat_d    = 1'b1;
                end else begin
                    res_d[r] = rsh[r][M-1:0];
                end
`else
                res_d[r] = rsh[r][M-1:0];
`endif
            end
        end
    end

`ifndef VERTEX_XFORM_SAT_EN
    logic [4*(SW+1-M)-1:0] unused_rsh_hi;
    assign unused_rsh_hi = {rsh[0][SW:M], rsh[1][SW:M], rsh[2][SW:M], rsh[3][SW:M]};
`endif

    always_comb begin
        s1_valid_d = ce ? in_valid   : s1_valid_q;
        s2_valid_d = ce ? s1_valid_q : s2_valid_q;
        s3_valid_d = ce ? s2_valid_q : s3_valid_q;
        cnt_d      = cnt_q;
        if (s3_valid_q && out_ready) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                shadow_q[i] <= (i % 5 == 0) ? ONE_Q : '0;
                active_q[i] <= (i % 5 == 0) ? ONE_Q : '0;
            end
            for (int r = 0; r < 4; r++) res_q[r] <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            cnt_q      <= '0;
`ifdef VERTEX_XFORM_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < 16; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
            for (int r = 0; r < 4; r++) res_q[r] <= res_d[r];
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            cnt_q      <= cnt_d;
`ifdef VERTEX_XFORM_SAT_EN
            sat_q      <= sat_d;
`endif
        end
    end

    // Intermediate stage data carries no reset; the valids gate it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 16; i++) prod_q[i] <= prod_d[i];
        for (int r = 0; r < 4; r++)  sum_q[r]  <= sum_d[r];
    end

    assign out_valid = s3_valid_q;
    assign out_x     = res_q[0];
    assign out_y     = res_q[1];
    assign out_z     = res_q[2];
    assign out_w     = res_q[3];
    assign vtx_count = cnt_q;
`ifdef VERTEX_XFORM_SAT_EN
    assign sat_flag  = sat_q;
`else
    assign sat_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_vertex_xform_pipe.sv
module tb_vertex_xform_pipe;

    localparam int M = 11;
    localparam int N = 7;
    localparam int W = M + N;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           mat_we = 1'b0;
    logic [3:0]     mat_addr = '0;
    logic [W-1:0]   mat_wdata = '0;
    logic           mat_commit = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_x = '0, in_y = '0, in_z = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [M-1:0]   out_x, out_y, out_z, out_w;
    logic [31:0]    vtx_count;
    logic           sat_flag;

    vertex_xform_pipe #(.M(M), .N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .mat_we(mat_we), .mat_addr(mat_addr), .mat_wdata(mat_wdata),
        .mat_commit(mat_commit),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_w(out_w),
        .vtx_count(vtx_count), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic longint sx(input logic [M-1:0] v);
        return longint'($signed(v));
    endfunction

    // ---------------- reference model ----------------
    longint        shd_m [16];
    longint        act_m [16];
    logic [4*M:0]  exp_q [$];     // {sat, w, z, y, x}
    logic [31:0]   m_count;
    bit            m_sat;
    bit            prev_stall;
    logic [4*M-1:0] prev_out;

    function automatic logic [4*M:0] model_xform(input longint x, input longint y, input longint z);
        longint v [4];
        longint s, q;
        logic [4*M:0] res;
        res = '0;
        v[0] = x; v[1] = y; v[2] = z; v[3] = longint'(1) << N;
        for (int r = 0; r < 4; r++) begin
            s = longint'(1) << (2*N-1);
            for (int c = 0; c < 4; c++) s = s + act_m[r*4+c] * v[c];
            q = s >>> (2*N);
`ifdef VERTEX_XFORM_SAT_EN
            if (q > 1023) begin q = 1023; res[4*M] = 1'b1; end
            else if (q < -1024) begin q = -1024; res[4*M] = 1'b1; end
`endif
            res[r*M +: M] = M'(q);
        end
        return res;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            shd_m[i] = (i % 5 == 0) ? 128 : 0;
            act_m[i] = (i % 5 == 0) ? 128 : 0;
        end
        exp_q.delete();
        m_count = '0;
        m_sat = 1'b0;
        prev_stall = 1'b0;
    endtask

    // Compare process: inputs and outputs are stable at the falling edge,
    // and describe what happens at the next rising edge.
    always @(negedge clk) begin
        logic [4*M-1:0] cur;
        cur = {out_w, out_z, out_y, out_x};
        if (!rst_n) begin
            model_reset();
        end else begin
            chk("vtx_count", vtx_count, m_count);
            chk("in_ready", in_ready, longint'(!out_valid || out_ready));
            chk("sat_flag", sat_flag,
                longint'(m_sat || (out_valid && exp_q.size() > 0 && exp_q[0][4*M])));
            if (prev_stall) chk("stall_stable", longint'(cur == prev_out), 1);
            if (out_valid) begin
                chk("out_expected", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("out_x", sx(out_x), sx(exp_q[0][0 +: M]));
                    chk("out_y", sx(out_y), sx(exp_q[0][M +: M]));
                    chk("out_z", sx(out_z), sx(exp_q[0][2*M +: M]));
                    chk("out_w", sx(out_w), sx(exp_q[0][3*M +: M]));
                    if (out_ready) begin
                        m_sat = m_sat | exp_q[0][4*M];
                        void'(exp_q.pop_front());
                        m_count = m_count + 32'd1;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out = cur;
            if (in_valid && in_ready) begin
                exp_q.push_back(model_xform(longint'($signed(in_x)),
                                            longint'($signed(in_y)),
                                            longint'($signed(in_z))));
                chk("inflight_le3", longint'(exp_q.size() <= 3), 1);
            end
            if (mat_commit) for (int i = 0; i < 16; i++) act_m[i] = shd_m[i];
            if (mat_we) shd_m[mat_addr] = longint'($signed(mat_wdata));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vtx(input int x, input int y, input int z);
        in_x = W'(x); in_y = W'(y); in_z = W'(z);
    endtask

    task automatic send(input int x, input int y, input int z);
        bit acc;
        int n;
        set_vtx(x, y, z);
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            acc = in_ready;
            step();
            n++;
        end
        in_valid = 1'b0;
        chk("send_accepted", longint'(acc), 1);
    endtask

    task automatic get_out(output logic [4*M-1:0] o);
        bit got;
        got = 1'b0;
        o = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (out_valid) begin
                o = {out_w, out_z, out_y, out_x};
                got = 1'b1;
            end
            step();
        end
        chk("out_timeout", longint'(got), 1);
    endtask

    task automatic load_matrix(input int m [16]);
        for (int i = 0; i < 16; i++) begin
            mat_we = 1'b1;
            mat_addr = 4'(i);
            mat_wdata = W'(m[i]);
            step();
        end
        mat_we = 1'b0;
    endtask

    task automatic commit();
        mat_commit = 1'b1;
        step();
        mat_commit = 1'b0;
    endtask

    function automatic int rnd_coord();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 262143)) - 131072;
        return int'($urandom_range(0, 16383)) - 8192;
    endfunction

    function automatic int rnd_coef();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 262143)) - 131072;
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    initial begin
        logic [4*M-1:0] o;
        int m2 [16];
        int d2 [16];
        int idm [16];
        int acc;

        m2  = '{83, -48, -83, 0, 34, 118, -34, 0, 90, 0, 90, 0, 0, 0, 0, 128};
        d2  = '{256, 0, 0, 0, 0, 256, 0, 0, 0, 0, 256, 0, 0, 0, 0, 256};
        idm = '{128, 0, 0, 0, 0, 128, 0, 0, 0, 0, 128, 0, 0, 0, 0, 128};

        step(); step();
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_vtx_count", vtx_count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sat", sat_flag, 0);

        // identity after reset, latency 3
        send(640, -384, 256);
        chk("lat_c1", out_valid, 0);
        step();
        chk("lat_c2", out_valid, 0);
        step();
        chk("lat_c3", out_valid, 1);
        chk("id_x", sx(out_x), 5);
        chk("id_y", sx(out_y), -3);
        chk("id_z", sx(out_z), 2);
        chk("id_w", sx(out_w), 1);
        step();
        chk("id_count", vtx_count, 1);

        // loaded rotation-like matrix
        load_matrix(m2);
        commit();
        send(128, 0, 0);
        get_out(o);
        chk("m2_x", sx(o[0 +: M]), 1);
        chk("m2_y", sx(o[M +: M]), 0);
        chk("m2_z", sx(o[2*M +: M]), 1);
        chk("m2_w", sx(o[3*M +: M]), 1);

        // out-of-range result
        load_matrix(d2);
        commit();
        send(76800, 0, 0);
        get_out(o);
`ifdef VERTEX_XFORM_SAT_EN
        chk("range_x", sx(o[0 +: M]), 1023);
        chk("range_sat", sat_flag, 1);
`else
        chk("range_x", sx(o[0 +: M]), -848);
        chk("range_sat", sat_flag, 0);
`endif

        // backpressure: exactly 3 accepted
        out_ready = 1'b0;
        set_vtx(rnd_coord(), rnd_coord(), rnd_coord());
        in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            bit a;
            a = in_ready;
            step();
            if (a) begin
                acc++;
                set_vtx(rnd_coord(), rnd_coord(), rnd_coord());
            end
        end
        chk("bp_accepted", acc, 3);
        chk("bp_in_ready", in_ready, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_drain_valid", out_valid, 1);
            step();
        end
        chk("bp_drain_end", out_valid, 0);

        // commit on acceptance cycle of A; B sees the new matrix
        load_matrix(idm);
        set_vtx(1280, 256, -640);
        in_valid = 1'b1;
        mat_commit = 1'b1;
        chk("cmt_ready", in_ready, 1);
        step();
        mat_commit = 1'b0;
        step();
        in_valid = 1'b0;
        get_out(o);
        chk("cmtA_x", sx(o[0 +: M]), 20);
        chk("cmtA_z", sx(o[2*M +: M]), -10);
        chk("cmtA_w", sx(o[3*M +: M]), 2);
        get_out(o);
        chk("cmtB_x", sx(o[0 +: M]), 10);
        chk("cmtB_z", sx(o[2*M +: M]), -5);
        chk("cmtB_w", sx(o[3*M +: M]), 1);

        // write + commit in the same cycle: active keeps the old entry
        mat_we = 1'b1; mat_addr = 4'd0; mat_wdata = W'(384); mat_commit = 1'b1;
        step();
        mat_we = 1'b0; mat_commit = 1'b0;
        send(1280, 256, -640);
        get_out(o);
        chk("wc_old_x", sx(o[0 +: M]), 10);
        commit();
        send(1280, 256, -640);
        get_out(o);
        chk("wc_new_x", sx(o[0 +: M]), 30);

        // randomized traffic with matrix updates
        for (int i = 0; i < 1500; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            set_vtx(rnd_coord(), rnd_coord(), rnd_coord());
            out_ready  = ($urandom_range(0, 3) != 0);
            mat_we     = ($urandom_range(0, 7) == 0);
            mat_addr   = 4'($urandom_range(0, 15));
            mat_wdata  = W'(rnd_coef());
            mat_commit = ($urandom_range(0, 15) == 0);
            step();
        end
        in_valid = 1'b0; mat_we = 1'b0; mat_commit = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("rand_drained", exp_q.size(), 0);

        // reset with 3 vertices in flight
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_vtx(rnd_coord(), rnd_coord(), rnd_coord());
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", vtx_count, 0);
        chk("mid_rst_sat", sat_flag, 0);
        chk("mid_rst_ready", in_ready, 1);
        out_ready = 1'b1;
        send(640, -384, 256);
        get_out(o);
        chk("post_rst_x", sx(o[0 +: M]), 5);
        chk("post_rst_y", sx(o[M +: M]), -3);
        chk("post_rst_z", sx(o[2*M +: M]), 2);
        chk("post_rst_w", sx(o[3*M +: M]), 1);
        for (int i = 0; i < 5; i++) step();
        chk("post_rst_count", vtx_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vertex_xform_pipe.md
# vertex_xform_pipe

Synthesizable, parametrised successor to the behavioural vertex processor. It streams object-space vertices (x, y, z; w = 1.0 implied) in signed fixed-point Q(M).(N) through a 4x4 fixed-point transform. It emits rounded integer (x, y, z, w) in M-bit signed, ready for the rasterizer. The matrix is double-buffered so it can be updated between vertices without draining the pipe.

## Interface
Parameters:
- M, 11, integer bits of fixed-point format and output width
- N, 7, fractional bits of fixed-point format

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- mat_we  in  1  write one shadow-matrix entry
- mat_addr  in  4  entry index, row-major (row*4+col)
- mat_wdata  in  M+N  signed Q(M).(N) coefficient
- mat_commit  in  1  copy shadow matrix to active matrix
- in_valid  in  1  input vertex valid
- in_ready  out  1  input vertex accepted when in_valid && in_ready
- in_x, in_y, in_z  in  M+N each  signed Q(M).(N) coordinates
- out_valid  out  1  output vertex valid
- out_ready  in  1  downstream accepts
- out_x, out_y, out_z, out_w  out  M each  signed integer results
- vtx_count  out  32  number of completed output handshakes, wraps at 2^32
- sat_flag  out  1  sticky: some result was out of range (cleared only by reset)

## Operation
- Per accepted vertex: out_r = (sum over c of A[r][c]*v[c] + 2^(2N-1)) >>> 2N, with v = (in_x, in_y, in_z, 2^N). This rounds half toward +inf.
- Widths: products are 2(M+N) bits, the sum is 2(M+N)+2 bits, and there is no intermediate truncation.
- Range reduction to M bits is defined under Configuration.
- Matrix banks: shadow and active, 16 entries each.
- Reset loads both banks with identity: diagonal = 2^N, others 0.
- mat_we writes shadow[mat_addr] at the clock edge.
- mat_commit copies the whole shadow bank to active at the clock edge.
- mat_we and mat_commit in the same cycle: commit copies the pre-write shadow value, and the write lands in shadow only.
- Matrix binding: a vertex uses the active matrix present on its acceptance cycle.
  - A commit on that same cycle does not affect it.
  - A commit affects vertices accepted on later cycles.
  - Vertices already in flight keep their matrix.
- Pipeline, three stages:
  - S1: register 16 products.
  - S2: register 4 row sums.
  - S3: round, reduce range, register outputs.
- All stages advance on ce = !s3_valid || out_ready; in_ready = ce.
- Stall holds all stage data and valids unchanged. Bubbles are not collapsed while stalled.
- vtx_count increments on each out_valid && out_ready.

## Timing
- Latency: a vertex accepted on cycle t gives out_valid on cycle t+3 if no stall occurs.
- Throughput: one vertex per cycle.
- Reset, synchronous, while rst_n = 0 at the edge:
  - all stage valids, out_valid, out_x/y/z/w, vtx_count and sat_flag become 0;
  - in_ready = 1 from the first cycle after reset;
  - in-flight vertices are discarded, with no partial output;
  - both matrix banks return to identity.
- out_x/y/z/w are stable while out_valid && !out_ready.
- Output content is don't-care when out_valid = 0, but implementation holds the last value.
- Maximum in-flight vertices: 3. With out_ready held low, exactly 3 vertices are accepted before in_ready falls.

## Configuration
- VERTEX_XFORM_SAT_EN defined:
  - results outside [-2^(M-1), 2^(M-1)-1] clamp to the nearest bound;
  - sat_flag is set on the S3 cycle that clamps, and is sticky.
- VERTEX_XFORM_SAT_EN undefined:
  - results wrap (keep the low M bits, two's complement), matching the behavioural model;
  - sat_flag is tied to 0.

## Test plan
- Identity after reset, vertex (640, -384, 256) = (5, -3, 2) -> (5, -3, 2, 1) at t+3, vtx_count = 1.
- Load rows {83,-48,-83,0},{34,118,-34,0},{90,0,90,0},{0,0,0,128}, commit, vertex (128, 0, 0) -> (1, 0, 1, 1).
- Diagonal 256 (2.0), commit, vertex x = 76800 (600), y = z = 0:
  - with SAT_EN -> out_x = 1023, sat_flag = 1;
  - without SAT_EN -> out_x = -848, sat_flag = 0.
- Backpressure: in_valid held high, out_ready low 10 cycles -> exactly 3 accepted, in_ready = 0, outputs stable. Release -> outputs in order, one per cycle, none lost or duplicated.
- Commit on the acceptance cycle of vertex A, followed by vertex B -> A uses the old matrix, B the new. mat_we to an entry plus commit in the same cycle -> active keeps the old value.
- rst_n low for 1 cycle with 3 vertices in flight -> out_valid = 0, vtx_count = 0, matrix identity, no stale vertex appears afterwards.
